abs_accumulator: RTL

- Downstream consumer of absolute_value.
- Accepts a stream of 8-bit magnitudes over a valid/ready handshake and accumulates a block of N_SAMPLES of them.
- For each block, publishes the sum of magnitudes, the peak magnitude and the index of that peak as one registered result.
- Feeds the register/display stage that reads block statistics.

---
 rtl/abs_accumulator.sv | 117 +++++++++++
 1 files changed

// File: rtl/abs_accumulator.sv
// Block statistics for a stream of unsigned magnitudes: per block of N_SAMPLES,
// publish the sum, the peak and the 0-based index of the first peak.
module abs_accumulator #(
  parameter int N_SAMPLES = 8,
  parameter int IDX_WIDTH = 3,
  parameter int SUM_WIDTH = 11
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic [7:0]           abs_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [SUM_WIDTH-1:0] sum_out,
  output logic [7:0]           peak_out,
  output logic [IDX_WIDTH-1:0] peak_idx,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_SAMPLES - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [IDX_WIDTH-1:0] count_p0;
  logic [SUM_WIDTH-1:0] acc_sum_p0;
  logic [7:0]           acc_peak_p0;
  logic [IDX_WIDTH-1:0] acc_idx_p0;

  logic [SUM_WIDTH-1:0] sum_nxt;
  logic [7:0]           peak_nxt;
  logic [IDX_WIDTH-1:0] idx_nxt;
  logic                 take;
  logic                 last;

  // Sample 0 always claims the peak so a block of zeros reports peak 0 at index 0.
  function automatic logic takes_peak(input logic [IDX_WIDTH-1:0] idx,
                                      input logic [7:0]           mag,
                                      input logic [7:0]           peak);
    return (idx == '0) || (mag > peak);
  endfunction

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign take      = in_valid && in_ready && !clear;
  assign last      = take && (count_p0 == LAST_IDX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (last) state_nxt = HOLD;
        HOLD:    if (out_ready) state_nxt = ACCUM;
        default: state_nxt = ACCUM;
      endcase
    end
  end

  always_comb begin
    sum_nxt  = acc_sum_p0 + SUM_WIDTH'(abs_in);
    peak_nxt = acc_peak_p0;
    idx_nxt  = acc_idx_p0;
    if (takes_peak(count_p0, abs_in, acc_peak_p0)) begin
      peak_nxt = abs_in;
      idx_nxt  = count_p0;
    end
  end

  // Stage p0: running accumulators; result registers load on the last sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_p0    <= '0;
      acc_sum_p0  <= '0;
      acc_peak_p0 <= '0;
      acc_idx_p0  <= '0;
      sum_out     <= '0;
      peak_out    <= '0;
      peak_idx    <= '0;
    end else if (clear) begin
      count_p0    <= '0;
      acc_sum_p0  <= '0;
      acc_peak_p0 <= '0;
      acc_idx_p0  <= '0;
    end else if (take) begin
      if (last) begin
        sum_out     <= sum_nxt;
        peak_out    <= peak_nxt;
        peak_idx    <= idx_nxt;
        count_p0    <= '0;
        acc_sum_p0  <= '0;
        acc_peak_p0 <= '0;
        acc_idx_p0  <= '0;
      end else begin
        count_p0    <= count_p0 + IDX_WIDTH'(1);
        acc_sum_p0  <= sum_nxt;
        acc_peak_p0 <= peak_nxt;
        acc_idx_p0  <= idx_nxt;
      end
    end
  end

endmodule
